// File: rtl/mul_share_pkg.sv
// mul_share_pkg: shared FSM encoding and widths for the multiplier-sharing arbiter
package mul_share_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, RESP = 2'd2} state_t;
  localparam int OPW = 8;
  localparam int PW = 16;
  localparam int NREQ_DEF = 4;
endpackage

// File: rtl/mul_share_rr.sv
// mul_share_rr: round-robin one-hot grant, searching circularly from ptr+1
module mul_share_rr #(
  parameter int NREQ = 4,
  parameter int IDW = 2
) (
  input  logic [NREQ-1:0] req_valid,
  input  logic [IDW-1:0]  ptr,
  output logic [NREQ-1:0] grant
);
  logic [IDW-1:0] j;
  // walk from the farthest candidate inward so the nearest valid one wins
  always_comb begin
    grant = '0;
    j = '0;
    for (int k = NREQ; k >= 1; k--) begin
      j = IDW'((int'(ptr) + k) % NREQ);
      if (req_valid[j]) grant = NREQ'(1) << j;
    end
  end
endmodule

// File: rtl/wallace_8x8_product.sv
// wallace_8x8_product: unsigned 8x8 combinational multiplier, carry-save reduction of partial products
module wallace_8x8_product (
  input  logic [7:0]  a,
  input  logic [7:0]  b,
  output logic [15:0] z
);
  logic [15:0] s, c, pp, t;
  always_comb begin
    s = '0;
    c = '0;
    pp = '0;
    t = '0;
    for (int i = 0; i < 8; i++) begin
      pp = b[i] ? 16'(a) << i : '0;
      t = s ^ c ^ pp;
      c = ((s & c) | (s & pp) | (c & pp)) << 1;
      s = t;
    end
    z = s + c;
  end
endmodule

// File: rtl/mul_share_arbiter.sv
// mul_share_arbiter: round-robin sharing of one 8x8 multiplier; define MUL_SHARE_STATS_EN to add op_count
module mul_share_arbiter
  import mul_share_pkg::*;
#(
  parameter int NREQ = NREQ_DEF,
  parameter int IDW = 2
) (
  input  logic              clk,
  input  logic              clrn,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [OPW*NREQ-1:0] req_a,
  input  logic [OPW*NREQ-1:0] req_b,
  output logic [NREQ-1:0]   req_ready,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [IDW-1:0]    rsp_id,
  output logic [PW-1:0]     rsp_z
`ifdef MUL_SHARE_STATS_EN
  , output logic [15:0]     op_count
`endif
);
  state_t state;
  logic [OPW-1:0] op_a, op_b;
  logic [IDW-1:0] id_r, ptr, gidx;
  logic [NREQ-1:0] grant;
  logic [PW-1:0] prod;
  mul_share_rr #(.NREQ(NREQ), .IDW(IDW)) u_rr (.req_valid(req_valid), .ptr(ptr), .grant(grant));
  wallace_8x8_product u_mul (.a(op_a), .b(op_b), .z(prod));
  assign req_ready = state == IDLE ? grant : '0;
  always_comb begin
    gidx = '0;
    for (int i = 0; i < NREQ; i++) if (grant[i]) gidx = IDW'(i);
  end
  always_ff @(posedge clk or negedge clrn)
    if (!clrn) begin
      state <= IDLE;
      op_a <= '0;
      op_b <= '0;
      id_r <= '0;
      ptr <= IDW'(NREQ - 1);
      rsp_valid <= 1'b0;
      rsp_id <= '0;
      rsp_z <= '0;
    end else
      case (state)
        IDLE: if (|grant) begin
          op_a <= req_a[gidx*OPW +: OPW];
          op_b <= req_b[gidx*OPW +: OPW];
          id_r <= gidx;
          ptr <= gidx;
          state <= CALC;
        end
        CALC: begin
          rsp_z <= prod;
          rsp_id <= id_r;
          rsp_valid <= 1'b1;
          state <= RESP;
        end
        RESP: if (rsp_ready) begin
          rsp_valid <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
`ifdef MUL_SHARE_STATS_EN
  always_ff @(posedge clk or negedge clrn)
    if (!clrn) op_count <= '0;
    else if (rsp_valid && rsp_ready) op_count <= op_count + 16'd1;
`endif
endmodule

// File: tb/tb_mul_share_arbiter.sv
// tb_mul_share_arbiter: randomized + directed scoreboard bench for mul_share_arbiter
module tb_mul_share_arbiter;
  localparam int N = 4;
  logic clk = 0, clrn = 1, rsp_ready = 0;
  logic [N-1:0] req_valid = '0, req_ready;
  logic [8*N-1:0] req_a = '0, req_b = '0;
  logic rsp_valid;
  logic [1:0] rsp_id;
  logic [15:0] rsp_z;
`ifdef MUL_SHARE_STATS_EN
  logic [15:0] op_count;
`endif
  int tests = 0, fails = 0;
  always #5 clk = ~clk;

  mul_share_arbiter #(.NREQ(N), .IDW(2)) dut (
    .clk(clk), .clrn(clrn), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_z(rsp_z)
`ifdef MUL_SHARE_STATS_EN
    , .op_count(op_count)
`endif
  );

  task automatic check(string name, int got, int exp);
    tests++;
    if (got != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  typedef struct { int id; int z; } exp_t;
  exp_t q[$];
  bit mbusy = 0;
  int age = 0, last = N - 1, done_cnt = 0;

  // reference model: who should be offered a grant, when the response is due, what it carries
  always @(negedge clk) begin
    logic [N-1:0] er;
    int w;
    if (!clrn) begin
      mbusy = 0;
      age = 0;
      last = N - 1;
      q.delete();
    end else begin
      er = '0;
      w = -1;
      if (!mbusy)
        for (int k = 1; k <= N; k++)
          if (w < 0 && req_valid[(last + k) % N]) w = (last + k) % N;
      if (w >= 0) er[w] = 1'b1;
      check("req_ready", int'(req_ready), int'(er));
      check("rsp_valid_timing", int'(rsp_valid), int'(mbusy && age >= 2));
      if (mbusy) begin
        if (age >= 2 && rsp_valid && rsp_ready) mbusy = 0;
        else age++;
      end else if (w >= 0) begin
        q.push_back('{w, int'(req_a[w*8 +: 8]) * int'(req_b[w*8 +: 8])});
        mbusy = 1;
        age = 1;
        last = w;
      end
    end
  end

  // monitor: compares every presented response against the head of the scoreboard
  always @(negedge clk) begin
    if (!clrn) done_cnt = 0;
    else if (rsp_valid) begin
      if (q.size() == 0) check("rsp_unexpected", 1, 0);
      else begin
        check("rsp_id", int'(rsp_id), q[0].id);
        check("rsp_z", int'(rsp_z), q[0].z);
        if (rsp_ready) begin
          void'(q.pop_front());
          done_cnt++;
        end
      end
    end
  end

  bit pend[N], keep[N];
  logic [7:0] pa[N], pb[N];

  task automatic issue(int i, int a, int b);
    pend[i] = 1;
    pa[i] = 8'(a);
    pb[i] = 8'(b);
  endtask

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      req_valid[i] = pend[i];
      req_a[i*8 +: 8] = pa[i];
      req_b[i*8 +: 8] = pb[i];
    end
  endtask

  task automatic step();
    logic [N-1:0] acc;
    @(negedge clk);
    acc = clrn ? req_valid & req_ready : '0;
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++)
      if (acc[i]) begin
        pend[i] = keep[i];
        pa[i] = 8'($urandom);
        pb[i] = 8'($urandom);
      end
    drive();
  endtask

  function automatic bit any_pend();
    for (int i = 0; i < N; i++) if (pend[i]) return 1;
    return 0;
  endfunction

  task automatic wait_idle(string name);
    int n = 0;
    while ((any_pend() || mbusy) && n < 300) begin
      step();
      n++;
    end
    check(name, int'(n < 300), 1);
  endtask

  task automatic pulse_reset();
    clrn = 0;
    @(posedge clk);
    #1 clrn = 1;
  endtask

  initial begin
    int n;
    #1 clrn = 0;
    #1;
    check("reset_rsp_valid", int'(rsp_valid), 0);
    check("reset_rsp_id", int'(rsp_id), 0);
    check("reset_rsp_z", int'(rsp_z), 0);
    check("reset_req_ready", int'(req_ready), 0);
    repeat (2) @(posedge clk);
    #1 clrn = 1;
    rsp_ready = 1;
    issue(0, 6, 9);
    drive();
    wait_idle("single_done");
    pulse_reset();
    issue(0, 14, 12); issue(1, 10, 11); issue(2, 15, 15); issue(3, 6, 9);
    drive();
    wait_idle("all4_done");
    rsp_ready = 0;
    issue(2, 255, 255);
    drive();
    repeat (3) step();
    issue(1, 1, 2);
    drive();
    repeat (10) step();
    check("bp_hold_valid", int'(rsp_valid), 1);
    check("bp_hold_z", int'(rsp_z), 65025);
    rsp_ready = 1;
    wait_idle("bp_done");
    keep[1] = 1; keep[3] = 1;
    issue(1, 3, 5); issue(3, 7, 11);
    drive();
    repeat (20) step();
    keep[1] = 0; keep[3] = 0;
    wait_idle("fair_done");
    issue(1, 3, 4);
    drive();
    n = 0;
    while (pend[1] && n < 50) begin step(); n++; end
    clrn = 0;
    #1;
    check("midop_rsp_valid", int'(rsp_valid), 0);
    issue(0, 7, 8); issue(2, 9, 9);
    drive();
    #1;
    check("midop_ptr_grant", int'(req_ready), 1);
    @(posedge clk);
    #1 clrn = 1;
    wait_idle("midop_done");
    repeat (400) begin
      for (int i = 0; i < N; i++)
        if (!pend[i] && $urandom_range(3) == 0)
          issue(i, $urandom_range(7) == 0 ? 255 : int'($urandom_range(255)),
                   $urandom_range(7) == 0 ? 255 : int'($urandom_range(255)));
        else if (pend[i] && $urandom_range(15) == 0) pend[i] = 0;
      rsp_ready = 1'($urandom_range(1));
      drive();
      step();
    end
    rsp_ready = 1;
    wait_idle("rand_drain");
    check("queue_empty", q.size(), 0);
`ifdef MUL_SHARE_STATS_EN
    check("op_count", int'(op_count), done_cnt & 16'hffff);
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time exceeded");
    $fatal(1);
  end
endmodule

// File: doc/mul_share_arbiter.md
Name: mul_share_arbiter

Overview:
- Shares one combinational 8x8 Wallace-tree multiplier (`wallace_8x8_product`) among NREQ requesters.
- Requesters use valid/ready handshakes; grants are round-robin.
- Operands are latched and the product is registered. The result is returned with the requester ID under a valid/ready response handshake.
- Sits between client datapaths and the multiplier; the multiplier instance lives inside this block.

Parameters:
- NREQ, 4, number of requesters; legal range 2..8.
- IDW, 2, width of requester ID; must equal ceil(log2(NREQ)).

Ports:
- clk  in  1  rising-edge clock
- clrn  in  1  asynchronous active-low reset
- req_valid  in  NREQ  per-requester request valid
- req_a  in  8*NREQ  operand A; requester i uses bits [8i+7:8i], unsigned
- req_b  in  8*NREQ  operand B; same slicing as req_a, unsigned
- req_ready  out  NREQ  per-requester accept; at most one bit high
- rsp_valid  out  1  response valid
- rsp_ready  in  1  response consumer ready
- rsp_id  out  IDW  index of the requester that owns the response
- rsp_z  out  16  unsigned product A*B

Behaviour:
- Reset (clrn=0, asynchronous):
  - state=IDLE, rsp_valid=0, rsp_id=0, rsp_z=0.
  - Operand registers cleared; last-grant pointer ptr=NREQ-1, so requester 0 has top priority first.
  - Reset mid-operation discards the in-flight op; no response is produced.
- FSM states: IDLE, CALC, RESP.
  - IDLE: grant = first set bit of req_valid, searching circularly from ptr+1.
    - req_ready = onehot(grant) while in IDLE and any req_valid is set; otherwise all zeros.
    - req_ready is combinational from req_valid and ptr.
    - On accept edge (req_valid[g] & req_ready[g]): latch req_a/req_b slice g into op_a/op_b, id_r=g, ptr=g, go to CALC.
  - CALC: op_a/op_b drive the multiplier. At the edge: rsp_z=product, rsp_id=id_r, rsp_valid=1, go to RESP.
  - RESP: hold rsp_valid, rsp_id and rsp_z stable until rsp_ready=1 at an edge, then rsp_valid=0 and go to IDLE.
    - req_ready stays 0 throughout CALC and RESP.
- Latency:
  - Accept edge E0; rsp_valid is high in the cycle after edge E0+1.
  - With rsp_ready tied high: one op per 3 cycles.
- Arithmetic: unsigned 8x8 -> 16-bit, no truncation. 255*255 = 65025 (16'hFE01).
- Fairness: a requester holding req_valid is granted within NREQ grants.
- Requester behaviour and stability:
  - Requesters may drop req_valid without being accepted; no state change results.
  - Operands are sampled only on the accept edge.
- Simultaneous events: if all requesters assert valid in IDLE, exactly one is accepted, chosen per ptr.
- Response backpressure: rsp_ready held 0 indefinitely leaves the FSM in RESP with outputs stable. rsp_ready outside RESP is ignored.

Optional Feature:
- Macro: MUL_SHARE_STATS_EN.
- Defined:
  - Extra output port op_count (16 bits): count of completed responses (rsp_valid & rsp_ready edges).
  - Reset to 0 by clrn; wraps 16'hFFFF -> 0.
- Undefined: port and counter are absent; all other behaviour is identical.

Decomposition:
- Package mul_share_pkg holds:
  - state encoding constants: IDLE=2'd0, CALC=2'd1, RESP=2'd2;
  - operand width constant OPW=8 and product width PW=16;
  - NREQ default.
- One sub-module, the round-robin grant function: `mul_share_rr` (inputs req_valid and ptr; output one-hot grant). It is unit-tested separately.
- The multiplier is an instance of the existing `wallace_8x8_product`; it is not modified.

Test Plan:
- Single op: req 0 sends a=6, b=9 with rsp_ready=1. Expect rsp_valid 2 cycles after accept, rsp_id=0, rsp_z=54, then the FSM returns to IDLE.
- All four requests valid at once, operands (14,12), (10,11), (15,15), (6,9) for requesters 0..3:
  - Expect grant order 0,1,2,3.
  - Expect responses 168, 110, 225, 54 with matching rsp_id.
- Backpressure: hold rsp_ready=0 for 10 cycles in RESP with a=255, b=255.
  - Expect rsp_z=65025 stable and req_ready all 0 during the hold.
  - Release rsp_ready: one response consumed, then IDLE.
- Fairness: requesters 1 and 3 valid continuously. Expect alternating grants 1,3,1,3; never two consecutive grants to the same requester.
- Reset mid-op: assert clrn=0 during CALC. Expect:
  - rsp_valid=0 immediately (asynchronous);
  - state IDLE, ptr=NREQ-1;
  - no stale response after release;
  - the next accept goes to requester 0 if it is valid.
- With MUL_SHARE_STATS_EN: 5 completed ops -> op_count=5. Preload op_count=16'hFFFF, complete 1 more op -> 0.
